// File: rtl/interval_timer_irq_pkg.sv
// rtl/interval_timer_irq_pkg.sv - shared register map and field definitions
//
// Purpose: register addresses, CTRL/STATUS bit positions and the CTRL field
//          layout shared by the interval timer and its bench.
// Ports:   none (package).
package interval_timer_irq_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_EXP = 0;

  // Field order matches the CTRL bit indices above (ie is bit 2).
  typedef struct packed {
    logic ie;
    logic auto_rl;
    logic run;
  } ctrl_t;

  // CTRL as seen on the read bus: unused bits read 0.
  function automatic logic [15:0] ctrl_to_word(ctrl_t c);
    return {13'b0, c};
  endfunction

endpackage

// File: rtl/interval_timer_irq_if.sv
// rtl/interval_timer_irq_if.sv - peripheral bus and interrupt signals of the interval timer
//
// Purpose: bundles the register bus and interrupt lines between CPU and timer.
// Ports (signals):
//   en, wr_en, addr[1:0], data_in[15:0]  CPU -> timer register access
//   data_out[15:0]                       timer -> CPU read data
//   irq                                  timer -> CPU interrupt request
//   irq_ack                              CPU -> timer interrupt acknowledge
interface interval_timer_irq_if;
  logic        en;
  logic        wr_en;
  logic [1:0]  addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        irq;
  logic        irq_ack;

  modport master (
    output en, wr_en, addr, data_in, irq_ack,
    input  data_out, irq
  );

  modport slave (
    input  en, wr_en, addr, data_in, irq_ack,
    output data_out, irq
  );
endinterface

// File: rtl/interval_timer_irq_tick_prescaler.sv
// rtl/interval_timer_irq_tick_prescaler.sv - 24-bit prescaler producing a one-cycle tick
//
// Purpose: divides clk by PRESCALE+1 while run is high.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active high
//   run      in   count enable; when low the prescaler is held at PRESCALE
//   restart  in   reload PRESCALE so the next tick is a full period away
//   tick     out  one-cycle pulse each time the prescaler passes through 0
module tick_prescaler #(
  parameter int unsigned PRESCALE = 49_999
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam logic [23:0] PRESCALE_VAL = 24'(PRESCALE);

  logic [23:0] cnt;

  // A restart in the tick cycle discards that tick so callers see a clean
  // full period after restarting.
  assign tick = run & ~restart & (cnt == 24'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= PRESCALE_VAL;
    end else if (!run || restart || cnt == 24'd0) begin
      cnt <= PRESCALE_VAL;
    end else begin
      cnt <= cnt - 24'd1;
    end
  end

endmodule

// File: rtl/interval_timer_irq.sv
// rtl/interval_timer_irq.sv - memory-mapped interval timer with interrupt request
//
// Purpose: counts down COUNT once per prescaler tick; on expiry sets the
//          sticky EXP flag and raises irq (when IE) until acked or cleared.
// Ports:
//   clk   in     clock, rising edge
//   rst   in     synchronous reset, active high
//   bus   slave  register bus (en, wr_en, addr, data_in, data_out) and
//                interrupt lines (irq, irq_ack)
module interval_timer_irq
  import interval_timer_irq_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY  = 50_000_000,
  parameter int unsigned TICKS_PER_SECOND = 1000,
  parameter int unsigned PRESCALE         = CLOCK_FREQUENCY / TICKS_PER_SECOND - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  interval_timer_irq_if.slave  bus
);

  ctrl_t       ctrl;
  logic [15:0] reload;
  logic [15:0] count;
  logic        exp_flag;
  logic        irq_q;

  logic  wr;
  logic  wr_ctrl;
  logic  wr_reload;
  logic  wr_count;
  logic  wr_status;
  ctrl_t ctrl_in;
  logic  restart;
  logic  tick;
  logic  expire;
  logic  exp_clear;
  logic  exp_next;

  assign wr        = bus.en & bus.wr_en;
  assign wr_ctrl   = wr & (bus.addr == ADDR_CTRL);
  assign wr_reload = wr & (bus.addr == ADDR_RELOAD);
  assign wr_count  = wr & (bus.addr == ADDR_COUNT);
  assign wr_status = wr & (bus.addr == ADDR_STATUS);
  assign ctrl_in   = ctrl_t'(bus.data_in[2:0]);

  // Prescaler restarts on a COUNT write and on the RUN 0->1 edge.
  assign restart = wr_count | (wr_ctrl & ctrl_in.run & ~ctrl.run);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_tick_prescaler (
    .clk     (clk),
    .rst     (rst),
    .run     (ctrl.run),
    .restart (restart),
    .tick    (tick)
  );

  // A COUNT write overrides the tick, so it also suppresses expiry.
  assign expire    = tick & ~wr_count & (count == 16'd1);
  assign exp_clear = bus.irq_ack | (wr_status & bus.data_in[STATUS_EXP]);
  // Set beats clear so an expiry coinciding with a clear is never lost.
  assign exp_next  = expire | (exp_flag & ~exp_clear);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= '0;
      reload   <= '0;
      count    <= '0;
      exp_flag <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= ctrl_in;
      if (wr_reload) reload <= bus.data_in;

      // Expiry uses the CTRL/RELOAD values from before any same-cycle write.
      if (wr_count) begin
        count <= bus.data_in;
      end else if (expire) begin
        count <= ctrl.auto_rl ? reload : 16'd0;
      end else if (tick && count > 16'd1) begin
        count <= count - 16'd1;
      end

      exp_flag <= exp_next;
      irq_q    <= exp_next & ctrl.ie;
    end
  end

  assign bus.irq = irq_q;

  always_comb begin
    bus.data_out = 16'd0;
    case (bus.addr)
      ADDR_CTRL:   bus.data_out = ctrl_to_word(ctrl);
      ADDR_RELOAD: bus.data_out = reload;
      ADDR_COUNT:  bus.data_out = count;
      ADDR_STATUS: bus.data_out = {15'b0, exp_flag};
      default:     bus.data_out = 16'd0;
    endcase
  end

endmodule

// File: doc/interval_timer_irq.md
Name: interval_timer_irq

Overview:
- Memory-mapped interval timer that initiates interrupts toward the CPU, rather than being polled like the existing countdown timer.
- Counts down in millisecond ticks derived from the system clock.
- On expiry, sets a sticky flag and raises an interrupt request. The request is held until the CPU acknowledges it or clears the flag.
- Sits on the peripheral bus beside the existing timer and feeds the CPU interrupt input.

Parameters:
- CLOCK_FREQUENCY, 50_000_000, system clock frequency in Hz.
- TICKS_PER_SECOND, 1000, timer tick rate.
- PRESCALE, CLOCK_FREQUENCY/TICKS_PER_SECOND-1, prescaler reload value. Must fit in 24 bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active high.
- en  in  1  peripheral select.
- wr_en  in  1  write strobe; acts only when en=1.
- addr  in  2  register select.
- data_in  in  16  write data.
- data_out  out  16  read data; combinational from addr, independent of en.
- irq  out  1  interrupt request; level; registered.
- irq_ack  in  1  single-cycle pulse from the CPU interrupt controller.

Behaviour:
- Register map:
  - 0 CTRL: bit0 RUN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable). Other bits read 0.
  - 1 RELOAD: 16-bit reload value.
  - 2 COUNT: current count; writable.
  - 3 STATUS: bit0 EXP (sticky expiry flag). Writing 1 to bit0 clears EXP; writing 0 has no effect.
- Reset values: CTRL=0, RELOAD=0, COUNT=0, EXP=0, prescaler=PRESCALE, irq=0.
- Prescaler (24-bit):
  - While RUN=1, it decrements each clk. At 0 it reloads PRESCALE and asserts an internal tick for one cycle.
  - While RUN=0, it is held at PRESCALE.
  - A write to CTRL that sets RUN from 0 to 1 reloads PRESCALE.
  - A write to COUNT reloads PRESCALE, so the first tick after the write is a full PRESCALE+1 cycles later.
- On tick:
  - COUNT>1: COUNT-=1.
  - COUNT==1: expiry. Set EXP, then COUNT<=RELOAD if AUTO=1, else COUNT<=0.
  - COUNT==0: no change and no expiry. The timer is idle; RUN is left unchanged.
- The expiry period in auto-reload mode is RELOAD ticks.
- RELOAD=0 with AUTO=1: expiry once, then the timer idles at 0.
- irq is registered: irq <= EXP_next & IE. It rises 1 cycle after the expiry edge.
- irq_ack=1 clears EXP, with the same effect as writing 1 to STATUS.0.
- Clearing IE drops irq the next cycle; EXP stays set.
- Priority within a single cycle, highest first: rst > COUNT write > tick decrement/expiry.
- Simultaneous expiry and clear (STATUS write or irq_ack): set wins, EXP=1. A fresh event must never be lost.
- Writes to CTRL or RELOAD in the same cycle as an expiry: the reload uses the old RELOAD value; the new CTRL takes effect next cycle.
- A reset in mid-count returns every register to its reset value in the next cycle.
- data_out returns registers zero-extended; the value is stable for the whole cycle.

Decomposition:
- Shared package holds the register address constants (CTRL, RELOAD, COUNT, STATUS), the CTRL bit indices (RUN, AUTO, IE) and STATUS bit EXP.
- One natural sub-module: tick_prescaler. It takes parameter PRESCALE and ports clk, rst, run, restart, and produces tick.
- tick_prescaler is reusable by the existing timer.

Test Plan:
Bench parameters: CLOCK_FREQUENCY=10 and TICKS_PER_SECOND=1, giving PRESCALE=9 (tick every 10 clk).
- Reset: hold rst 2 cycles, release -> all reads 0, irq=0; no ticks over 50 cycles with RUN=0.
- One-shot: write COUNT=3, CTRL=0b101 -> COUNT reads 2, 1, 0 at ticks 1–3; EXP=1 at tick 3; irq=1 one cycle later; COUNT stays 0 for a further 50 cycles.
- Auto-reload: RELOAD=4, COUNT=4, CTRL=0b111 -> expiry every 40 cycles; after 3 expiries COUNT reloads to 4 each time; pulse irq_ack after each expiry -> irq drops next cycle.
- Clear race: in the same cycle as an expiry, write STATUS=1 -> EXP stays 1 and irq stays 1; a later STATUS=1 write clears both.
- Masking: IE=0 with expiry -> EXP=1, irq=0; then set IE=1 -> irq=1 the next cycle.
- Write priority: write COUNT=7 in the same cycle as a tick with COUNT=5 -> COUNT reads 7; next tick exactly 10 cycles later -> COUNT reads 6.
